input_wr_buf: RTL

- Per-port data buffer that sits in parallel with input_ctrl on the write path.
- Captures every packet word (header word included) from the port as soon as it arrives.
- Holds the words while input_ctrl waits for a block address from the address manager.
- Pops one word per i_sram_addr_vld pulse from input_ctrl and issues a registered SRAM write (address, data, enable) to the shared cache SRAM.

---
 rtl/mpcache_pkg.sv | 19 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/input_wr_buf.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mpcache_pkg.sv
// Shared write-path types: word/address widths, receive FSM states, SRAM write bundle.
// No logic; imported by the input buffer and its FIFO wrapper.
package mpcache_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } sram_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with pointer-derived level/full/empty.
// Latency: push visible to pop the next cycle; pop data registered, valid 1 cycle after pop.
// Backpressure: none; a push while full (and not popping) is dropped, a pop while empty returns 0.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_drop,
    output logic                     pop_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;
    assign pop_drop  = pop && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pop_dat <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (pop)     pop_dat <= pop_ok ? mem[rd_ptr[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/input_wr_buf.sv
// Per-port write buffer: captures packet words, releases one per SRAM address pulse (INPUT_WR_BUF_PARITY_EN adds parity).
// Latency: SRAM write issued exactly 1 cycle after i_sram_addr_vld.
// Backpressure: none to the port; o_afull/o_full advise, overflowing words are lost and flagged sticky.
module input_wr_buf #(
    parameter int DATA_WIDTH = mpcache_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mpcache_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 64,
    parameter int AFULL_TH   = 48
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_sop,
    input  logic                    i_wr_vld,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic                    i_eop,
    input  logic [ADDR_WIDTH-1:0]   i_sram_addr,
    input  logic                    i_sram_addr_vld,
    output logic                    o_sram_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_sram_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_sram_wr_data,
    output logic                    o_afull,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic [15:0]             o_drop_cnt
`ifdef INPUT_WR_BUF_PARITY_EN
    ,
    output logic                    o_parity_err
`endif
);

    import mpcache_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;
`ifdef INPUT_WR_BUF_PARITY_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif

    rx_state_e       state;
    rx_state_e       state_nxt;
    logic            push;
    logic            drop;
    logic [EW-1:0]   push_dat;
    logic [EW-1:0]   rd_dat;
    logic [LW-1:0]   fifo_level;
    logic            push_drop;
    logic            pop_drop;
    logic            wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    sram_wr_t        sram_wr;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_sop) begin
                    push      = i_wr_vld;
                    state_nxt = (i_wr_vld && i_eop) ? S_IDLE : S_RECV;
                end else begin
                    drop = i_wr_vld;
                end
            end
            S_RECV: begin
                push = i_wr_vld;
                if (i_wr_vld && i_eop) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef INPUT_WR_BUF_PARITY_EN
    assign push_dat = {^i_wr_data, i_wr_data};
`else
    assign push_dat = i_wr_data;
`endif

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (i_sram_addr_vld),
        .pop_dat   (rd_dat),
        .full      (o_full),
        .empty     (o_empty),
        .level     (fifo_level),
        .push_drop (push_drop),
        .pop_drop  (pop_drop)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_drop_cnt  <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state <= state_nxt;
            if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
            if (push_drop) o_overflow  <= 1'b1;
            if (pop_drop)  o_underflow <= 1'b1;
            wr_en_q   <= i_sram_addr_vld;
            wr_addr_q <= i_sram_addr;
        end
    end

    // Data is already registered inside the FIFO, so it lines up with en/addr.
    always_comb begin
        sram_wr      = '0;
        sram_wr.en   = wr_en_q;
        sram_wr.addr = wr_addr_q;
        sram_wr.data = rd_dat[DATA_WIDTH-1:0];
    end

    assign o_sram_wr_en   = sram_wr.en;
    assign o_sram_wr_addr = sram_wr.addr;
    assign o_sram_wr_data = sram_wr.data;
    assign o_level        = fifo_level;
    assign o_afull        = (fifo_level >= LW'(AFULL_TH));

`ifdef INPUT_WR_BUF_PARITY_EN
    // Even parity: stored bit plus data XOR to zero for an intact entry.
    assign o_parity_err = wr_en_q && (^rd_dat);
`endif

endmodule
